// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants, state encodings and the frame parity helper
// used by the frame receiver and the keycode decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] KEY_W = 8'h1D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  typedef enum logic [1:0] {
    BASE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } byte_state_t;

  // Data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data_bits, input logic parity_bit);
    return ^{data_bits, parity_bit};
  endfunction

endpackage

// File: rtl/ps2_keycode_decoder_frame_rx.sv
// PS/2 frame receiver: synchronizes and de-glitches the keyboard pins, then
// assembles 11-bit frames into bytes with start/parity/stop/timeout checks.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_rdy,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_ZERO = FW'(0);
  localparam logic [FW-1:0] FILT_INC  = FW'(1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_ZERO   = TW'(0);
  localparam logic [TW-1:0] TO_INC    = TW'(1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic          filt_r;
  logic          fall_r;
  logic [FW-1:0] filt_cnt_r;
  frame_state_t  state_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_ok_r;
  logic [TW-1:0] to_cnt_r;
  logic [7:0]    rx_byte_r;
  logic          byte_rdy_r;
  logic          frame_err_r;

  // Two-flop synchronizers for both pins, idling high like the bus.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Clock glitch filter; a 1->0 change of the filtered level emits fall_r.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      filt_r     <= 1'b1;
      filt_cnt_r <= FILT_ZERO;
      fall_r     <= 1'b0;
    end else begin
      fall_r <= 1'b0;
      if (clk_sync_r[1] == filt_r) begin
        filt_cnt_r <= FILT_ZERO;
      end else if (filt_cnt_r == FILT_LAST) begin
        filt_r     <= clk_sync_r[1];
        filt_cnt_r <= FILT_ZERO;
        fall_r     <= filt_r;
      end else begin
        filt_cnt_r <= filt_cnt_r + FILT_INC;
      end
    end
  end

  // Frame FSM with the inter-edge timeout watchdog.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'd0;
      parity_ok_r <= 1'b0;
      to_cnt_r    <= TO_ZERO;
      rx_byte_r   <= 8'd0;
      byte_rdy_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      byte_rdy_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (fall_r) begin
        to_cnt_r <= TO_ZERO;
        case (state_r)
          IDLE: begin
            if (!data_sync_r[1]) begin
              state_r   <= DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              frame_err_r <= 1'b1;
            end
          end
          DATA: begin
            shift_r <= {data_sync_r[1], shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              state_r <= PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          PARITY: begin
            parity_ok_r <= odd_parity_ok(shift_r, data_sync_r[1]);
            state_r     <= STOP;
          end
          STOP: begin
            if (data_sync_r[1] && parity_ok_r) begin
              byte_rdy_r <= 1'b1;
              rx_byte_r  <= shift_r;
            end else begin
              frame_err_r <= 1'b1;
            end
            state_r <= IDLE;
          end
          default: state_r <= IDLE;
        endcase
      end else if (state_r != IDLE) begin
        if (to_cnt_r == TO_LAST) begin
          frame_err_r <= 1'b1;
          state_r     <= IDLE;
          bit_cnt_r   <= 3'd0;
          to_cnt_r    <= TO_ZERO;
        end else begin
          to_cnt_r <= to_cnt_r + TO_INC;
        end
      end else begin
        to_cnt_r <= TO_ZERO;
      end
    end
  end

  assign rx_byte   = rx_byte_r;
  assign byte_rdy  = byte_rdy_r;
  assign frame_err = frame_err_r;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard front end: strips E0/F0 prefixes from received bytes and
// tracks the make code of the currently held key for the player logic.
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       press,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0]  rx_byte_s;
  logic        byte_rdy_s;
  logic        frame_err_s;
  byte_state_t bstate_r;
  logic [7:0]  keycode_r;
  logic        extended_r;
  logic        press_r;
  logic        key_valid_r;
  logic        frame_err_r;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte_s),
    .byte_rdy  (byte_rdy_s),
    .frame_err (frame_err_s)
  );

  // Prefix tracking; a break only releases press when code and prefix both match.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bstate_r    <= BASE;
      keycode_r   <= 8'd0;
      extended_r  <= 1'b0;
      press_r     <= 1'b0;
      key_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      frame_err_r <= frame_err_s;
      if (byte_rdy_s) begin
        case (bstate_r)
          BASE, GOT_E0: begin
            if (rx_byte_s == PS2_EXT) begin
              bstate_r <= GOT_E0;
            end else if (rx_byte_s == PS2_BRK) begin
              bstate_r <= (bstate_r == GOT_E0) ? GOT_E0F0 : GOT_F0;
            end else begin
              keycode_r   <= rx_byte_s;
              extended_r  <= (bstate_r == GOT_E0);
              press_r     <= 1'b1;
              key_valid_r <= 1'b1;
              bstate_r    <= BASE;
            end
          end
          GOT_F0, GOT_E0F0: begin
            if ((rx_byte_s == keycode_r) && ((bstate_r == GOT_E0F0) == extended_r)) begin
              press_r <= 1'b0;
            end else begin
              press_r <= press_r;
            end
            key_valid_r <= 1'b1;
            bstate_r    <= BASE;
          end
          default: bstate_r <= BASE;
        endcase
      end else begin
        bstate_r <= bstate_r;
      end
    end
  end

  assign keycode   = keycode_r;
  assign extended  = extended_r;
  assign press     = press_r;
  assign key_valid = key_valid_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Directed bench: a table of single frames with expected decoder state, plus
// hand sequences for bad start, timeout and mid-frame reset.
module tb_ps2_keycode_decoder;

  localparam int FLEN = 8;
  localparam int TO   = 1000;
  localparam int HALF = 20;
  localparam int GAP  = 60;
  localparam int NV   = 19;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       extended;
  logic       press;
  logic       key_valid;
  logic       frame_err;

  int cyc = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int kv_cyc = 0;
  int fe_cyc = 0;
  int last_fall_cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic [7:0] exp_kc;
    logic       exp_ext;
    logic       exp_press;
    int         exp_kv;
    int         exp_fe;
  } vec_t;

  vec_t vecs [NV];

  ps2_keycode_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TO)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .extended  (extended),
    .press     (press),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (key_valid) begin
      kv_cnt <= kv_cnt + 1;
      kv_cyc <= cyc;
    end
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge Clk);
    ps2_data = b;
    repeat (HALF) @(negedge Clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge Clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad);
    send_bit(1'b1);
    @(negedge Clk);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge Clk);
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] kc, input logic ext, input logic pr);
    chk({tag, " keycode"}, int'(keycode), int'(kc));
    chk({tag, " extended"}, int'(extended), int'(ext));
    chk({tag, " press"}, int'(press), int'(pr));
  endtask

  initial begin
    int  kv0;
    int  fe0;
    logic got;

    vecs[0]  = '{8'h1C, 1'b0, 8'h1C, 1'b0, 1'b1, 1, 0};
    vecs[1]  = '{8'h1C, 1'b0, 8'h1C, 1'b0, 1'b1, 1, 0};
    vecs[2]  = '{8'hF0, 1'b0, 8'h1C, 1'b0, 1'b1, 0, 0};
    vecs[3]  = '{8'h1C, 1'b0, 8'h1C, 1'b0, 1'b0, 1, 0};
    vecs[4]  = '{8'hE0, 1'b0, 8'h1C, 1'b0, 1'b0, 0, 0};
    vecs[5]  = '{8'h74, 1'b0, 8'h74, 1'b1, 1'b1, 1, 0};
    vecs[6]  = '{8'hF0, 1'b0, 8'h74, 1'b1, 1'b1, 0, 0};
    vecs[7]  = '{8'h74, 1'b0, 8'h74, 1'b1, 1'b1, 1, 0};
    vecs[8]  = '{8'hE0, 1'b0, 8'h74, 1'b1, 1'b1, 0, 0};
    vecs[9]  = '{8'hF0, 1'b0, 8'h74, 1'b1, 1'b1, 0, 0};
    vecs[10] = '{8'h74, 1'b0, 8'h74, 1'b1, 1'b0, 1, 0};
    vecs[11] = '{8'h23, 1'b1, 8'h74, 1'b1, 1'b0, 0, 1};
    vecs[12] = '{8'h23, 1'b0, 8'h23, 1'b0, 1'b1, 1, 0};
    vecs[13] = '{8'h1C, 1'b0, 8'h1C, 1'b0, 1'b1, 1, 0};
    vecs[14] = '{8'hF0, 1'b0, 8'h1C, 1'b0, 1'b1, 0, 0};
    vecs[15] = '{8'h23, 1'b0, 8'h1C, 1'b0, 1'b1, 1, 0};
    vecs[16] = '{8'hE0, 1'b0, 8'h1C, 1'b0, 1'b1, 0, 0};
    vecs[17] = '{8'hE0, 1'b0, 8'h1C, 1'b0, 1'b1, 0, 0};
    vecs[18] = '{8'h1D, 1'b0, 8'h1D, 1'b1, 1'b1, 1, 0};

    repeat (3) @(negedge Clk);
    chk_outs("reset", 8'h00, 1'b0, 1'b0);
    chk("reset key_valid", int'(key_valid), 0);
    chk("reset frame_err", int'(frame_err), 0);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);

    for (int i = 0; i < NV; i++) begin
      kv0 = kv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[i].data, vecs[i].bad_par);
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_kc, vecs[i].exp_ext, vecs[i].exp_press);
      chk($sformatf("vec%0d key_valid pulses", i), kv_cnt - kv0, vecs[i].exp_kv);
      chk($sformatf("vec%0d frame_err pulses", i), fe_cnt - fe0, vecs[i].exp_fe);
      if (vecs[i].exp_kv == 1)
        chk_range($sformatf("vec%0d latency", i), kv_cyc - last_fall_cyc, FLEN + 2, FLEN + 6);
    end

    // A falling edge with data high is a bad start bit.
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_bit(1'b1);
    repeat (GAP) @(negedge Clk);
    chk("bad start frame_err", fe_cnt - fe0, 1);
    chk("bad start key_valid", kv_cnt - kv0, 0);
    chk_outs("bad start", 8'h1D, 1'b1, 1'b1);

    // Partial frame abandoned until the watchdog fires.
    fe0 = fe_cnt;
    kv0 = kv_cnt;
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    got = 1'b0;
    for (int k = 0; k < TO + 200 && !got; k++) begin
      @(negedge Clk);
      if (fe_cnt != fe0) got = 1'b1;
    end
    chk("timeout fired", int'(got), 1);
    chk_range("timeout latency", fe_cyc - last_fall_cyc, TO, TO + FLEN + 6);
    repeat (GAP) @(negedge Clk);
    chk("timeout frame_err pulses", fe_cnt - fe0, 1);
    chk("timeout key_valid", kv_cnt - kv0, 0);
    chk_outs("timeout", 8'h1D, 1'b1, 1'b1);
    @(negedge Clk);
    ps2_data = 1'b1;
    send_frame(8'h1D, 1'b0);
    chk_outs("post timeout", 8'h1D, 1'b0, 1'b1);

    // Reset in the middle of a frame clears everything asynchronously.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge Clk);
    ps2_data = 1'b1;
    #2 Reset = 1'b1;
    #1;
    chk_outs("mid reset", 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0);
    chk_outs("post reset", 8'h1C, 1'b0, 1'b1);
    chk("post reset key_valid", kv_cnt - kv0, 1);
    chk("post reset frame_err", fe_cnt - fe0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
